// File: rtl/long_wb_scoreboard_pkg.sv
// rtl/long_wb_scoreboard_pkg.sv - shared widths and entry type for the long-latency writeback scoreboard
//
// Purpose: register-index width and the scoreboard entry record.
// Ports: none (package).
package long_wb_scoreboard_pkg;

  // Register-file address width (stands in for the core's MYRISCV_REGADDRBUS define).
  localparam int REGADDRBUS = 5;

  typedef struct packed {
    logic                  vld;
    logic [REGADDRBUS-1:0] rd;
  } sb_entry_t;

endpackage

// File: rtl/long_wb_scoreboard_sb_free_pick.sv
// rtl/long_wb_scoreboard_sb_free_pick.sv - lowest-set-bit one-hot finder over the free-slot vector
//
// Purpose: picks the lowest-index free scoreboard slot.
// Ports:
//   i_free [DEPTH]  1 = slot is free
//   o_oh   [DEPTH]  one-hot of the lowest free slot (all zero if none)
//   o_any           at least one slot is free
module sb_free_pick #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0] i_free,
  output logic [DEPTH-1:0] o_oh,
  output logic             o_any
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    o_oh = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (i_free[i]) begin
        o_oh    = '0;
        o_oh[i] = 1'b1;
      end
    end
  end

  assign o_any = |i_free;

endmodule

// File: rtl/long_wb_scoreboard.sv
// rtl/long_wb_scoreboard.sv - pending-destination scoreboard for long-latency instructions
//
// Purpose: records destinations of outstanding long instructions between dispatch
// and writeback, stalls dispatch on RAW/WAW hazards or when full, frees entries on
// the writeback arbiter's clear pulse.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   disp_vld / disp_rdy            dispatch handshake (disp_rdy independent of disp_vld)
//   disp_long                      instruction allocates an entry on fire
//   disp_rd_en, disp_rd            destination
//   disp_rs1_en/rs1, rs2_en/rs2    sources
//   clr_req, clr_idx               writeback clear of a pending destination
//   pend_cnt, empty, full          occupancy, registered-state derived
//   clr_err                        sticky: a clear matched no valid entry
module long_wb_scoreboard
  import long_wb_scoreboard_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  disp_vld,
  output logic                  disp_rdy,
  input  logic                  disp_long,
  input  logic                  disp_rd_en,
  input  logic [REGADDRBUS-1:0] disp_rd,
  input  logic                  disp_rs1_en,
  input  logic [REGADDRBUS-1:0] disp_rs1,
  input  logic                  disp_rs2_en,
  input  logic [REGADDRBUS-1:0] disp_rs2,
  input  logic                  clr_req,
  input  logic [REGADDRBUS-1:0] clr_idx,
  output logic [CW-1:0]         pend_cnt,
  output logic                  empty,
  output logic                  full,
  output logic                  clr_err
);

  sb_entry_t        r_ent [DEPTH];
  logic [CW-1:0]    r_cnt;
  logic             r_clr_err;

  logic [DEPTH-1:0] w_free;
  logic [DEPTH-1:0] w_free_oh;
  logic             w_free_any;
  logic [DEPTH-1:0] w_clr_hit;
  logic             w_raw;
  logic             w_waw;
  logic             w_full;
  logic             w_alloc_en;
  logic             w_fire;
  logic             w_alloc;
  logic             w_clr_any;

  // Hazards and clear matches look only at registered entries, so a clear in
  // this cycle cannot unblock a stalled instruction until the next cycle.
  always_comb begin
    w_raw     = 1'b0;
    w_waw     = 1'b0;
    w_free    = '0;
    w_clr_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_free[i] = ~r_ent[i].vld;
      if (r_ent[i].vld) begin
        if (disp_rs1_en && (disp_rs1 != '0) && (r_ent[i].rd == disp_rs1)) w_raw = 1'b1;
        if (disp_rs2_en && (disp_rs2 != '0) && (r_ent[i].rd == disp_rs2)) w_raw = 1'b1;
        if (disp_rd_en  && (disp_rd  != '0) && (r_ent[i].rd == disp_rd))  w_waw = 1'b1;
        w_clr_hit[i] = (r_ent[i].rd == clr_idx);
      end
    end
  end

  sb_free_pick #(.DEPTH(DEPTH)) u_free_pick (
    .i_free (w_free),
    .o_oh   (w_free_oh),
    .o_any  (w_free_any)
  );

  assign w_full     = (r_cnt == CW'(DEPTH));
  assign w_alloc_en = disp_rd_en & (disp_rd != '0);
  assign disp_rdy   = ~w_raw & ~w_waw & ~(disp_long & w_alloc_en & w_full);
  assign w_fire     = disp_vld & disp_rdy;
  // w_free_any is implied by ~w_full; kept as a guard against a stale count.
  assign w_alloc    = w_fire & disp_long & w_alloc_en & w_free_any;
  assign w_clr_any  = clr_req & (|w_clr_hit);

  // The allocated slot comes from the pre-clear free set and the cleared slot is
  // a valid one, so the two updates never touch the same entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_cnt     <= '0;
      r_clr_err <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clr_req && w_clr_hit[i]) r_ent[i].vld <= 1'b0;
        if (w_alloc && w_free_oh[i]) begin
          r_ent[i].vld <= 1'b1;
          r_ent[i].rd  <= disp_rd;
        end
      end
      if (clr_req && !(|w_clr_hit)) r_clr_err <= 1'b1;
      case ({w_alloc, w_clr_any})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign pend_cnt = r_cnt;
  assign empty    = (r_cnt == '0);
  assign full     = w_full;
  assign clr_err  = r_clr_err;

endmodule

// File: tb/tb_long_wb_scoreboard.sv
// tb/tb_long_wb_scoreboard.sv - self-checking bench for long_wb_scoreboard
module tb_long_wb_scoreboard;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          disp_vld, disp_rdy, disp_long, disp_rd_en, disp_rs1_en, disp_rs2_en;
  logic [4:0]    disp_rd, disp_rs1, disp_rs2;
  logic          clr_req;
  logic [4:0]    clr_idx;
  logic [CW-1:0] pend_cnt;
  logic          empty, full, clr_err;

  int checks = 0;
  int errors = 0;

  // Reference model: set of pending destination registers plus sticky error.
  bit m_pend [32];
  bit m_err;

  always #5 clk = ~clk;

  long_wb_scoreboard #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_vld(disp_vld), .disp_rdy(disp_rdy), .disp_long(disp_long),
    .disp_rd_en(disp_rd_en), .disp_rd(disp_rd),
    .disp_rs1_en(disp_rs1_en), .disp_rs1(disp_rs1),
    .disp_rs2_en(disp_rs2_en), .disp_rs2(disp_rs2),
    .clr_req(clr_req), .clr_idx(clr_idx),
    .pend_cnt(pend_cnt), .empty(empty), .full(full), .clr_err(clr_err)
  );

  function automatic int m_cnt();
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(m_pend[r]);
    return n;
  endfunction

  function automatic bit m_rdy();
    bit raw, waw, alloc;
    raw   = (disp_rs1_en && disp_rs1 != 0 && m_pend[disp_rs1]) ||
            (disp_rs2_en && disp_rs2 != 0 && m_pend[disp_rs2]);
    alloc = disp_rd_en && disp_rd != 0;
    waw   = alloc && m_pend[disp_rd];
    return !raw && !waw && !(disp_long && alloc && m_cnt() == DEPTH);
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic set_in(input bit vld, input bit lng, input bit rd_en, input int rd,
                        input bit r1_en, input int r1, input bit r2_en, input int r2,
                        input bit clr, input int cidx);
    disp_vld = vld; disp_long = lng; disp_rd_en = rd_en; disp_rd = 5'(rd);
    disp_rs1_en = r1_en; disp_rs1 = 5'(r1); disp_rs2_en = r2_en; disp_rs2 = 5'(r2);
    clr_req = clr; clr_idx = 5'(cidx);
  endtask

  task automatic idle_in();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance one clock: model applies the clear to pre-state, then allocation.
  task automatic tick();
    bit fire;
    fire = disp_vld && m_rdy();
    @(posedge clk);
    if (clr_req) begin
      if (m_pend[clr_idx]) m_pend[clr_idx] = 1'b0;
      else m_err = 1'b1;
    end
    if (fire && disp_long && disp_rd_en && disp_rd != 0) m_pend[disp_rd] = 1'b1;
    @(negedge clk);
    idle_in();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_in();
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (pend_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d want 0", pend_cnt); end
    checks++; if (empty !== 1'b1 || full !== 1'b0 || clr_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags got e%b f%b c%b want e1 f0 c0", empty, full, clr_err); end
    checks++; if (disp_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b want 1", disp_rdy); end
  endtask

  task automatic test_long_alloc();
    set_in(1, 1, 1, 5, 0, 0, 0, 0, 0, 0); tick();
    checks++; if (pend_cnt !== CW'(1)) begin errors++; $display("FAIL alloc_cnt got %0d want 1", pend_cnt); end
    set_in(1, 0, 0, 0, 1, 5, 0, 0, 0, 0); #1;
    checks++; if (disp_rdy !== 1'b0) begin errors++; $display("FAIL raw_stall got %b want 0", disp_rdy); end
    // Clear in the same cycle must not unblock yet.
    clr_req = 1'b1; clr_idx = 5'd5; #1;
    checks++; if (disp_rdy !== 1'b0) begin errors++; $display("FAIL clr_same_cycle got %b want 0", disp_rdy); end
    tick();
    set_in(1, 0, 0, 0, 1, 5, 0, 0, 0, 0); #1;
    checks++; if (disp_rdy !== 1'b1 || empty !== 1'b1) begin
      errors++; $display("FAIL clr_unblock got rdy%b e%b want rdy1 e1", disp_rdy, empty); end
    tick();
  endtask

  task automatic test_fill_overflow();
    for (int r = 1; r <= 4; r++) begin set_in(1, 1, 1, r, 0, 0, 0, 0, 0, 0); tick(); end
    checks++; if (full !== 1'b1 || pend_cnt !== CW'(4)) begin
      errors++; $display("FAIL fill got f%b cnt%0d want f1 cnt4", full, pend_cnt); end
    set_in(1, 1, 1, 6, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (disp_rdy !== 1'b0) begin errors++; $display("FAIL full_long got %b want 0", disp_rdy); end
    tick();
    set_in(1, 0, 1, 6, 1, 8, 0, 0, 0, 0); #1;
    checks++; if (disp_rdy !== 1'b1) begin errors++; $display("FAIL full_short got %b want 1", disp_rdy); end
    tick();
    checks++; if (pend_cnt !== CW'(4)) begin errors++; $display("FAIL short_noalloc got %0d want 4", pend_cnt); end
  endtask

  task automatic test_alloc_clear();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 4); tick();  // down to 3: rd 1,2,3
    set_in(1, 1, 1, 9, 0, 0, 0, 0, 1, 2); #1;
    checks++; if (disp_rdy !== 1'b1) begin errors++; $display("FAIL ac_rdy got %b want 1", disp_rdy); end
    tick();
    checks++; if (pend_cnt !== CW'(3)) begin errors++; $display("FAIL ac_cnt got %0d want 3", pend_cnt); end
    set_in(0, 0, 0, 0, 1, 9, 0, 0, 0, 0); #1;
    checks++; if (disp_rdy !== 1'b0) begin errors++; $display("FAIL ac_9_valid got rdy %b want 0", disp_rdy); end
    set_in(0, 0, 0, 0, 0, 0, 1, 2, 0, 0); #1;
    checks++; if (disp_rdy !== 1'b1) begin errors++; $display("FAIL ac_2_free got rdy %b want 1", disp_rdy); end
    idle_in();
  endtask

  task automatic test_waw_x0();
    do_reset();
    set_in(1, 1, 1, 7, 0, 0, 0, 0, 0, 0); tick();
    set_in(1, 0, 1, 7, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (disp_rdy !== 1'b0) begin errors++; $display("FAIL waw got %b want 0", disp_rdy); end
    set_in(1, 1, 1, 0, 1, 0, 1, 0, 0, 0); #1;
    checks++; if (disp_rdy !== 1'b1) begin errors++; $display("FAIL x0_rdy got %b want 1", disp_rdy); end
    tick();
    checks++; if (pend_cnt !== CW'(1)) begin errors++; $display("FAIL x0_noalloc got %0d want 1", pend_cnt); end
  endtask

  task automatic test_clr_nomatch();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 12); tick();
    checks++; if (clr_err !== 1'b1 || pend_cnt !== CW'(1)) begin
      errors++; $display("FAIL nomatch got err%b cnt%0d want err1 cnt1", clr_err, pend_cnt); end
    set_in(0, 0, 1, 7, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (disp_rdy !== 1'b0) begin errors++; $display("FAIL nomatch_keep got %b want 0", disp_rdy); end
    tick(); tick();
    checks++; if (clr_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", clr_err); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int r = 10; r <= 12; r++) begin set_in(1, 1, 1, r, 0, 0, 0, 0, 0, 0); tick(); end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 20); tick();  // raise clr_err too
    set_in(1, 1, 1, 11, 1, 10, 1, 12, 0, 0);
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    checks++; if (pend_cnt !== '0 || empty !== 1'b1 || full !== 1'b0 || clr_err !== 1'b0) begin
      errors++; $display("FAIL async_rst got cnt%0d e%b f%b c%b want 0 1 0 0", pend_cnt, empty, full, clr_err); end
    checks++; if (disp_rdy !== 1'b1) begin errors++; $display("FAIL async_rst_rdy got %b want 1", disp_rdy); end
    @(negedge clk);
    rst_n = 1'b1;
    idle_in();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      int cidx;
      cidx = int'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        for (int r = 1; r < 8; r++) if (m_pend[r] && $urandom_range(0, 1) == 1) cidx = r;
      end
      set_in(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0),
             int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
             bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
             bit'($urandom_range(0, 2) == 0), cidx);
      #1;
      checks++; if (disp_rdy !== m_rdy()) begin
        errors++; $display("FAIL rnd_rdy n=%0d got %b want %b", n, disp_rdy, m_rdy()); end
      tick();
      checks++; if (pend_cnt !== CW'(m_cnt()) || empty !== (m_cnt() == 0) ||
                    full !== (m_cnt() == DEPTH) || clr_err !== m_err) begin
        errors++; $display("FAIL rnd_state n=%0d got cnt%0d e%b f%b c%b want cnt%0d c%b",
                           n, pend_cnt, empty, full, clr_err, m_cnt(), m_err); end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    idle_in();
    m_reset();
    test_reset();
    test_long_alloc();
    test_fill_overflow();
    test_alloc_clear();
    test_waw_x0();
    test_clr_nomatch();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
